// File: rtl/kes_mc_cpu.sv
// kes_mc_cpu: multicycle fetch/decode/execute core with separate instruction and
// data SRAM ports, both using a start/done handshake.
module kes_mc_cpu #(
  parameter  int DW = 8,
  parameter  int AW = 5,
  localparam int IW = AW + 3
) (
  input  logic          clock,
  input  logic          reset,
  output logic [AW-1:0] i_addr,
  output logic          i_start,
  input  logic [IW-1:0] i_rdata,
  input  logic          i_done,
  output logic [AW-1:0] d_addr,
  output logic          d_start,
  output logic          d_write,
  output logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] d_rdata,
  input  logic          d_done,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] ir,
  output logic [DW-1:0] d_reg,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halted
);

  typedef enum logic [2:0] {FETCH, DECODE, MEM, EXEC, HALT} state_t;
  typedef enum logic [2:0] {
    OP_LD1, OP_LD2, OP_SUB, OP_ADD, OP_ST, OP_JMP, OP_JZ, OP_HALT
  } op_t;

  state_t        state;
  op_t           op;
  logic [AW-1:0] arg;
  logic [DW-1:0] s1, s2;
  logic [DW:0]   alu_res;
  logic          i_req;

  assign op      = op_t'(ir[IW-1:IW-3]);
  assign arg     = ir[AW-1:0];
  assign i_addr  = pc;
  assign d_addr  = arg;
  assign d_wdata = d_reg;

  // i_req is high for the whole FETCH state; masking it with reset keeps the
  // port quiet while reset is held and lets the first fetch go out as soon as
  // reset drops.
  assign i_start = i_req & ~reset;

  // One extra bit holds carry-out for ADD and borrow for SUB.
  assign alu_res = (op == OP_SUB) ? ({1'b0, s1} - {1'b0, s2})
                                  : ({1'b0, s1} + {1'b0, s2});

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      s1      <= '0;
      s2      <= '0;
      d_reg   <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      i_req   <= 1'b1;
      d_start <= 1'b0;
      d_write <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (i_req && i_done) begin
            ir    <= i_rdata;
            pc    <= pc + 1'b1;
            i_req <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (op)
            OP_LD1, OP_LD2, OP_ST: begin
              d_start <= 1'b1;
              d_write <= (op == OP_ST);
              state   <= MEM;
            end
            OP_SUB, OP_ADD: state <= EXEC;
            OP_JMP: begin
              pc    <= arg;
              i_req <= 1'b1;
              state <= FETCH;
            end
            OP_JZ: begin
              if (flag_z) pc <= arg;
              i_req <= 1'b1;
              state <= FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
          endcase
        end
        MEM: begin
          if (d_start && d_done) begin
            if (op == OP_LD1) s1 <= d_rdata;
            if (op == OP_LD2) s2 <= d_rdata;
            d_start <= 1'b0;
            d_write <= 1'b0;
            i_req   <= 1'b1;
            state   <= FETCH;
          end
        end
        EXEC: begin
          d_reg  <= alu_res[DW-1:0];
          flag_z <= (alu_res[DW-1:0] == '0);
          flag_c <= alu_res[DW];
          i_req  <= 1'b1;
          state  <= FETCH;
        end
        HALT: halted <= 1'b1;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_kes_mc_cpu.sv
// Bench for kes_mc_cpu: directed scenarios plus random programs checked against
// an instruction-level model with per-instruction cycle costs.
module tb_kes_mc_cpu;
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: DW=8, AW=5 ----------------
  logic [4:0] a_i_addr, a_d_addr, a_pc;
  logic [7:0] a_i_rdata, a_ir, a_d_wdata, a_d_rdata, a_d;
  logic       a_i_start, a_i_done, a_d_start, a_d_write, a_d_done;
  logic       a_z, a_c, a_halted;

  kes_mc_cpu #(.DW(8), .AW(5)) dut_a (
    .clock(clk), .reset(rst),
    .i_addr(a_i_addr), .i_start(a_i_start), .i_rdata(a_i_rdata), .i_done(a_i_done),
    .d_addr(a_d_addr), .d_start(a_d_start), .d_write(a_d_write), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_done(a_d_done),
    .pc(a_pc), .ir(a_ir), .d_reg(a_d), .flag_z(a_z), .flag_c(a_c), .halted(a_halted)
  );

  // Memories: the initial process owns imem/dmem/latencies; stores land in a
  // separate array tagged with the current test generation.
  logic [7:0] imem [32];
  logic [7:0] dmem [32];
  logic [7:0] st_data [32];
  int         st_gen [32];
  int         gen = 1;
  int         li = 1, ld = 1;
  int         i_cnt = 0, d_cnt = 0;
  int         viol = 0;

  assign a_i_done  = a_i_start && (i_cnt >= li - 1);
  assign a_i_rdata = imem[a_i_addr];
  assign a_d_done  = a_d_start && (d_cnt >= ld - 1);
  assign a_d_rdata = (st_gen[a_d_addr] == gen) ? st_data[a_d_addr] : dmem[a_d_addr];

  always @(posedge clk) begin
    i_cnt <= (a_i_start && !a_i_done) ? i_cnt + 1 : 0;
    d_cnt <= (a_d_start && !a_d_done) ? d_cnt + 1 : 0;
    if (a_d_start && a_d_done && a_d_write) begin
      st_data[a_d_addr] <= a_d_wdata;
      st_gen[a_d_addr]  <= gen;
    end
  end

  always @(negedge clk) if (a_i_start && a_d_start) viol <= viol + 1;

  function automatic logic [7:0] dmem_rd(input int p);
    return (st_gen[p] == gen) ? st_data[p] : dmem[p];
  endfunction

  // ---------------- DUT B: DW=16, AW=8, latency 1 ----------------
  logic [7:0]  b_i_addr, b_d_addr, b_pc;
  logic [10:0] b_i_rdata, b_ir;
  logic [15:0] b_d_wdata, b_d_rdata, b_d;
  logic        b_i_start, b_i_done, b_d_start, b_d_write, b_d_done, b_z, b_c, b_halted;
  logic [10:0] bimem [256];
  logic [15:0] bdmem [256];
  logic [7:0]  b_st_addr = '0;
  logic [15:0] b_st_data = '0;
  int          b_st_cnt = 0;

  kes_mc_cpu #(.DW(16), .AW(8)) dut_b (
    .clock(clk), .reset(rst_b),
    .i_addr(b_i_addr), .i_start(b_i_start), .i_rdata(b_i_rdata), .i_done(b_i_done),
    .d_addr(b_d_addr), .d_start(b_d_start), .d_write(b_d_write), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done),
    .pc(b_pc), .ir(b_ir), .d_reg(b_d), .flag_z(b_z), .flag_c(b_c), .halted(b_halted)
  );

  assign b_i_done  = b_i_start;
  assign b_i_rdata = bimem[b_i_addr];
  assign b_d_done  = b_d_start;
  assign b_d_rdata = bdmem[b_d_addr];

  always @(posedge clk) begin
    if (b_d_start && b_d_write) begin
      b_st_addr <= b_d_addr;
      b_st_data <= b_d_wdata;
      b_st_cnt  <= b_st_cnt + 1;
    end
  end

  // ---------------- reference model (ISA level) ----------------
  logic [7:0] m_dmem [32];
  logic [7:0] m_d, m_ir;
  logic [4:0] m_pc;
  bit         m_z, m_c, m_halt;
  int         m_cyc;

  task automatic model_run(input int lat_i, input int lat_d, input int max_steps);
    int pc, s1, s2, d, op, a, r;
    bit z, c;
    for (int i = 0; i < 32; i++) m_dmem[i] = dmem[i];
    pc = 0; s1 = 0; s2 = 0; d = 0; z = 0; c = 0; m_cyc = 0; m_halt = 0; m_ir = 0;
    for (int step = 0; step < max_steps && !m_halt; step++) begin
      m_ir = imem[pc];
      op = int'(imem[pc]) / 32;
      a  = int'(imem[pc]) % 32;
      pc = (pc + 1) % 32;
      case (op)
        0: begin s1 = int'(m_dmem[a]); m_cyc += lat_i + 1 + lat_d; end
        1: begin s2 = int'(m_dmem[a]); m_cyc += lat_i + 1 + lat_d; end
        2: begin r = s1 - s2; c = (s1 < s2); d = (r + 256) % 256; z = (d == 0); m_cyc += lat_i + 2; end
        3: begin r = s1 + s2; c = (r > 255); d = r % 256; z = (d == 0); m_cyc += lat_i + 2; end
        4: begin m_dmem[a] = 8'(d); m_cyc += lat_i + 1 + lat_d; end
        5: begin pc = a; m_cyc += lat_i + 1; end
        6: begin if (z) pc = a; m_cyc += lat_i + 1; end
        default: begin m_halt = 1; m_cyc += lat_i + 1; end
      endcase
    end
    m_pc = 5'(pc); m_d = 8'(d); m_z = z; m_c = c;
  endtask

  // ---------------- helpers ----------------
  task automatic clear_a();
    gen++;
    for (int i = 0; i < 32; i++) begin
      imem[i] = 8'hE0;
      dmem[i] = 8'h00;
    end
  endtask

  task automatic reset_a(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // cycle 0 is the first negedge after reset drops (first fetch cycle)
  task automatic run_a(input int max, output int cyc, output bit ok);
    cyc = 0;
    @(negedge clk);
    while (!a_halted && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    ok = a_halted;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_a();
    li = 4; ld = 4;
    imem[0] = 8'h03; imem[1] = 8'h24; imem[2] = 8'h60; imem[3] = 8'hA0;
    dmem[3] = 8'h05; dmem[4] = 8'h07;
    reset_a(2);
    for (int k = 0; k <= 26; k++) @(negedge clk);
    checks++;
    if (a_i_start !== 1'b1 || a_i_addr !== 5'd3 || a_d !== 8'h0C) begin
      errors++;
      $display("FAIL rst_pre: i_start=%b i_addr=%h d=%h, need 1 03 0c", a_i_start, a_i_addr, a_d);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (a_i_start !== 1'b0 || a_d_start !== 1'b0 || a_d_write !== 1'b0 || a_pc !== 5'd0 ||
          a_ir !== 8'd0 || a_d !== 8'd0 || a_z !== 1'b0 || a_c !== 1'b0 || a_halted !== 1'b0) begin
        errors++;
        $display("FAIL rst_hold%0d: i_st=%b d_st=%b d_wr=%b pc=%h ir=%h d=%h z=%b c=%b h=%b, need all 0",
                 k, a_i_start, a_d_start, a_d_write, a_pc, a_ir, a_d, a_z, a_c, a_halted);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (a_i_start !== 1'b1 || a_i_addr !== 5'd0) begin
          errors++;
          $display("FAIL rst_first_fetch: i_start=%b i_addr=%h, need 1 00", a_i_start, a_i_addr);
        end
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (a_ir !== ((k == 4) ? 8'h03 : 8'h00)) begin
          errors++;
          $display("FAIL rst_refetch%0d: ir=%h, need %h", k, a_ir, (k == 4) ? 8'h03 : 8'h00);
        end
      end
    end
  endtask

  task automatic test_program();
    int cyc; bit ok; bit extra;
    clear_a();
    li = 1; ld = 1;
    imem[0] = 8'h03; imem[1] = 8'h24; imem[2] = 8'h40; imem[3] = 8'h85; imem[4] = 8'hE0;
    dmem[3] = 8'h05; dmem[4] = 8'h07;
    reset_a(2);
    run_a(100, cyc, ok);
    checks++;
    if (!ok || cyc !== 14) begin
      errors++;
      $display("FAIL prog_cycles: halted=%b at cycle %0d, need 1 at 14", ok, cyc);
    end
    checks++;
    if (a_d !== 8'hFE || a_c !== 1'b1 || a_z !== 1'b0) begin
      errors++;
      $display("FAIL prog_result: d=%h c=%b z=%b, need fe 1 0", a_d, a_c, a_z);
    end
    checks++;
    if (dmem_rd(5) !== 8'hFE) begin
      errors++;
      $display("FAIL prog_store: dmem[5]=%h, need fe", dmem_rd(5));
    end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_i_start || a_d_start || !a_halted) extra = 1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL prog_quiet: request or halt drop after HALT, got %b need 0", extra);
    end
  endtask

  task automatic test_add_jz();
    int cyc; bit ok;
    for (int t = 0; t < 2; t++) begin
      clear_a();
      li = 1; ld = 1;
      imem[0] = 8'h00; imem[1] = 8'h21; imem[2] = 8'h60; imem[3] = 8'hD0;
      imem[4] = 8'hE4; imem[16] = 8'hF0;
      dmem[0] = (t == 0) ? 8'hFF : 8'hFE; dmem[1] = 8'h01;
      model_run(li, ld, 64);
      reset_a(2);
      run_a(100, cyc, ok);
      checks++;
      if (!ok || cyc !== 13) begin
        errors++;
        $display("FAIL jz%0d_cycles: halted=%b cycle %0d, need 1 13", t, ok, cyc);
      end
      checks++;
      if (t == 0 && (a_d !== 8'h00 || a_z !== 1'b1 || a_c !== 1'b1 || a_pc !== 5'h11 || a_ir !== 8'hF0)) begin
        errors++;
        $display("FAIL jz_taken: d=%h z=%b c=%b pc=%h ir=%h, need 00 1 1 11 f0", a_d, a_z, a_c, a_pc, a_ir);
      end
      if (t == 1 && (a_d !== 8'hFF || a_z !== 1'b0 || a_c !== 1'b0 || a_pc !== 5'h05 || a_ir !== 8'hE4)) begin
        errors++;
        $display("FAIL jz_not_taken: d=%h z=%b c=%b pc=%h ir=%h, need ff 0 0 05 e4", a_d, a_z, a_c, a_pc, a_ir);
      end
      checks++;
      if (a_d !== m_d || a_pc !== m_pc || cyc !== m_cyc) begin
        errors++;
        $display("FAIL jz%0d_model: d=%h pc=%h cyc=%0d, need %h %h %0d", t, a_d, a_pc, cyc, m_d, m_pc, m_cyc);
      end
    end
  endtask

  task automatic test_wait_states();
    int cyc; logic exp_i, exp_d; logic [4:0] exp_ia;
    clear_a();
    li = 3; ld = 5;
    imem[0] = 8'h02; imem[1] = 8'h23; imem[2] = 8'h60; imem[3] = 8'hE0;
    dmem[2] = 8'hA5; dmem[3] = 8'h00;
    reset_a(2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_i  = (k < 3) || (k == 9);
      exp_d  = (k >= 4) && (k <= 8);
      exp_ia = (k == 9) ? 5'd1 : 5'd0;
      checks++;
      if (a_i_start !== exp_i || a_d_start !== exp_d ||
          (exp_d && (a_d_addr !== 5'd2 || a_d_write !== 1'b0)) ||
          (exp_i && a_i_addr !== exp_ia)) begin
        errors++;
        $display("FAIL wait_c%0d: i_st=%b d_st=%b d_addr=%h d_wr=%b i_addr=%h, need %b %b 02 0 %h",
                 k, a_i_start, a_d_start, a_d_addr, a_d_write, a_i_addr, exp_i, exp_d, exp_ia);
      end
      if (k == 7) dmem[2] = 8'h5A;
    end
    cyc = 9;
    while (!a_halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!a_halted || cyc !== 27 || a_d !== 8'h5A || a_z !== 1'b0 || a_c !== 1'b0) begin
      errors++;
      $display("FAIL wait_final: halted=%b cyc=%0d d=%h z=%b c=%b, need 1 27 5a 0 0",
               a_halted, cyc, a_d, a_z, a_c);
    end
  endtask

  task automatic test_pc_wrap();
    clear_a();
    li = 1; ld = 1;
    imem[0] = 8'hBF; imem[31] = 8'h60;
    reset_a(2);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (a_pc !== 5'd1 || a_ir !== 8'hBF) begin
          errors++;
          $display("FAIL wrap_jmp: pc=%h ir=%h, need 01 bf", a_pc, a_ir);
        end
      end
      if (k == 2 || k == 5) begin
        checks++;
        if (a_i_start !== 1'b1 || a_i_addr !== ((k == 2) ? 5'd31 : 5'd0)) begin
          errors++;
          $display("FAIL wrap_fetch%0d: i_start=%b i_addr=%h, need 1 %h", k, a_i_start, a_i_addr,
                   (k == 2) ? 5'd31 : 5'd0);
        end
      end
      if (k == 3) begin
        checks++;
        if (a_pc !== 5'd0 || a_ir !== 8'h60) begin
          errors++;
          $display("FAIL wrap_pc: pc=%h ir=%h, need 00 60", a_pc, a_ir);
        end
      end
    end
  endtask

  task automatic test_random();
    int cyc, bad, op, a;
    bit ok;
    for (int it = 0; it < 20; it++) begin
      clear_a();
      li = $urandom_range(4, 1);
      ld = $urandom_range(4, 1);
      for (int p = 0; p < 32; p++) dmem[p] = 8'($urandom);
      for (int p = 0; p < 31; p++) begin
        op = $urandom_range(6, 0);
        a  = $urandom_range(31, 0);
        if (op == 5 || op == 6) a = $urandom_range(31, p + 1);
        imem[p] = 8'(op * 32 + a);
      end
      imem[31] = 8'(7 * 32 + $urandom_range(31, 0));
      model_run(li, ld, 64);
      reset_a(2);
      run_a(800, cyc, ok);
      checks++;
      if (!ok || cyc !== m_cyc) begin
        errors++;
        $display("FAIL rnd%0d_cycles: halted=%b cyc=%0d, need 1 %0d", it, ok, cyc, m_cyc);
      end
      checks++;
      if (a_d !== m_d || a_z !== m_z || a_c !== m_c || a_pc !== m_pc || a_ir !== m_ir) begin
        errors++;
        $display("FAIL rnd%0d_regs: d=%h z=%b c=%b pc=%h ir=%h, need %h %b %b %h %h",
                 it, a_d, a_z, a_c, a_pc, a_ir, m_d, m_z, m_c, m_pc, m_ir);
      end
      bad = 0;
      for (int p = 0; p < 32; p++) if (dmem_rd(p) !== m_dmem[p]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd%0d_dmem: %0d words differ, need 0", it, bad);
      end
    end
  endtask

  task automatic test_param_sweep();
    int cyc;
    for (int i = 0; i < 256; i++) begin
      bimem[i] = 11'h700;
      bdmem[i] = 16'h0000;
    end
    bimem[0] = 11'h090; bimem[1] = 11'h191; bimem[2] = 11'h200;
    bimem[3] = 11'h4C5; bimem[4] = 11'h5A0; bimem[8'hA0] = 11'h7A0;
    bdmem[8'h90] = 16'h0000; bdmem[8'h91] = 16'h0001;
    @(posedge clk); #1 rst_b = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!b_halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!b_halted || cyc !== 16) begin
      errors++;
      $display("FAIL wide_cycles: halted=%b cyc=%0d, need 1 16", b_halted, cyc);
    end
    checks++;
    if (b_d !== 16'hFFFF || b_c !== 1'b1 || b_z !== 1'b0) begin
      errors++;
      $display("FAIL wide_sub: d=%h c=%b z=%b, need ffff 1 0", b_d, b_c, b_z);
    end
    checks++;
    if (b_pc !== 8'hA1 || b_ir !== 11'h7A0) begin
      errors++;
      $display("FAIL wide_pc: pc=%h ir=%h, need a1 7a0", b_pc, b_ir);
    end
    checks++;
    if (b_st_cnt !== 1 || b_st_addr !== 8'hC5 || b_st_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL wide_store: cnt=%0d addr=%h data=%h, need 1 c5 ffff", b_st_cnt, b_st_addr, b_st_data);
    end
  endtask

  task automatic test_port_exclusive();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL exclusive_start: %0d cycles with both starts high, need 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_add_jz();
    test_wait_states();
    test_pc_wrap();
    test_random();
    test_param_sweep();
    test_port_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
